// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types for the execute->memory pipeline register
package pipe_pkg;

  localparam int DATA_W = 32;

  typedef struct packed {
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] store_data;
    logic              we;
    logic              select_mem;
    logic              data_input_s;
    logic              data_input_on;
  } exmem_payload_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - load/clear register holding one execute->memory payload
module pipe_slot
  import pipe_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           i_clear,
  input  logic           i_load,
  input  exmem_payload_t i_d,
  output exmem_payload_t o_q
);

  exmem_payload_t r_q;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/exmem_skid_reg.sv
// rtl/exmem_skid_reg.sv - execute->memory register with 2-entry skid buffer,
// forwarding tap and saturating stall counter
module exmem_skid_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic [DATA_W-1:0] store_data_i,
  input  logic              we_i,
  input  logic              select_mem_i,
  input  logic              data_input_s_i,
  input  logic              data_input_on_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] alu_result_o,
  output logic [DATA_W-1:0] store_data_o,
  output logic              we_o,
  output logic              select_mem_o,
  output logic              data_input_s_o,
  output logic              data_input_on_o,
  output logic              fwd_valid_o,
  output logic [DATA_W-1:0] fwd_data_o,
  output logic [1:0]        occupancy_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  import pipe_pkg::*;

  skid_state_t    r_state;
  skid_state_t    w_state_nxt;
  exmem_payload_t w_in;
  exmem_payload_t w_main_d;
  exmem_payload_t w_main_q;
  exmem_payload_t w_skid_q;
  logic           w_accept;
  logic           w_issue;
  logic           w_main_load;
  logic           w_main_from_skid;
  logic           w_main_clear;
  logic           w_skid_load;
  logic           w_skid_clear;
  logic [CNT_W-1:0] r_stall_cnt;

  assign w_in = '{alu_result:    alu_result_i,
                  store_data:    store_data_i,
                  we:            we_i,
                  select_mem:    select_mem_i,
                  data_input_s:  data_input_s_i,
                  data_input_on: data_input_on_i};

  assign ready_o  = (r_state != FULL) && !reset;
  assign valid_o  = (r_state != EMPTY);
  assign w_accept = valid_i && ready_o;
  assign w_issue  = valid_o && ready_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_main_load      = 1'b0;
    w_main_from_skid = 1'b0;
    w_main_clear     = 1'b0;
    w_skid_load      = 1'b0;
    w_skid_clear     = 1'b0;
    if (flush) begin
      w_state_nxt  = EMPTY;
      w_main_clear = 1'b1;
      w_skid_clear = 1'b1;
    end else begin
      unique case (r_state)
        EMPTY: begin
          if (w_accept) begin
            w_main_load = 1'b1;
            w_state_nxt = ONE;
          end
        end
        ONE: begin
          if (w_accept && w_issue) begin
            w_main_load = 1'b1;
          end else if (w_accept) begin
            w_skid_load = 1'b1;
            w_state_nxt = FULL;
          end else if (w_issue) begin
            // Clearing on drain keeps the head outputs at zero while empty.
            w_main_clear = 1'b1;
            w_state_nxt  = EMPTY;
          end
        end
        FULL: begin
          if (w_issue) begin
            w_main_load      = 1'b1;
            w_main_from_skid = 1'b1;
            w_skid_clear     = 1'b1;
            w_state_nxt      = ONE;
          end
        end
        default: begin
          w_state_nxt  = EMPTY;
          w_main_clear = 1'b1;
          w_skid_clear = 1'b1;
        end
      endcase
    end
  end

  assign w_main_d = w_main_from_skid ? w_skid_q : w_in;

  pipe_slot u_main (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_main_clear),
    .i_load  (w_main_load),
    .i_d     (w_main_d),
    .o_q     (w_main_q)
  );

  pipe_slot u_skid (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_skid_clear),
    .i_load  (w_skid_load),
    .i_d     (w_in),
    .o_q     (w_skid_q)
  );

  // Stall counter ignores flush so stall statistics survive pipeline flushes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (valid_o && !ready_i && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign alu_result_o    = w_main_q.alu_result;
  assign store_data_o    = w_main_q.store_data;
  assign we_o            = w_main_q.we && valid_o;
  assign select_mem_o    = w_main_q.select_mem;
  assign data_input_s_o  = w_main_q.data_input_s;
  assign data_input_on_o = w_main_q.data_input_on;
  assign fwd_valid_o     = valid_o;
  assign fwd_data_o      = (r_state == FULL)  ? w_skid_q.alu_result :
                           (r_state == EMPTY) ? '0 : w_main_q.alu_result;
  assign occupancy_o     = (r_state == FULL) ? 2'd2 :
                           (r_state == ONE)  ? 2'd1 : 2'd0;
  assign stall_cnt_o     = r_stall_cnt;

endmodule

// File: tb/tb_exmem_skid_reg.sv
// tb/tb_exmem_skid_reg.sv - randomized and directed checks of exmem_skid_reg against a queue model
module tb_exmem_skid_reg;

  localparam int DATA_W  = 32;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              valid_i;
  logic              ready_o;
  logic [DATA_W-1:0] alu_result_i;
  logic [DATA_W-1:0] store_data_i;
  logic              we_i;
  logic              select_mem_i;
  logic              data_input_s_i;
  logic              data_input_on_i;
  logic              valid_o;
  logic              ready_i;
  logic [DATA_W-1:0] alu_result_o;
  logic [DATA_W-1:0] store_data_o;
  logic              we_o;
  logic              select_mem_o;
  logic              data_input_s_o;
  logic              data_input_on_o;
  logic              fwd_valid_o;
  logic [DATA_W-1:0] fwd_data_o;
  logic [1:0]        occupancy_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  exmem_skid_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .flush           (flush),
    .valid_i         (valid_i),
    .ready_o         (ready_o),
    .alu_result_i    (alu_result_i),
    .store_data_i    (store_data_i),
    .we_i            (we_i),
    .select_mem_i    (select_mem_i),
    .data_input_s_i  (data_input_s_i),
    .data_input_on_i (data_input_on_i),
    .valid_o         (valid_o),
    .ready_i         (ready_i),
    .alu_result_o    (alu_result_o),
    .store_data_o    (store_data_o),
    .we_o            (we_o),
    .select_mem_o    (select_mem_o),
    .data_input_s_o  (data_input_s_o),
    .data_input_on_o (data_input_on_o),
    .fwd_valid_o     (fwd_valid_o),
    .fwd_data_o      (fwd_data_o),
    .occupancy_o     (occupancy_o),
    .stall_cnt_o     (stall_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] sd;
    logic              we;
    logic              sm;
    logic              ds;
    logic              don;
  } beat_t;

  beat_t q[$];
  int    m_cnt = 0;
  int    n_err = 0;
  int    n_chk = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_update();
    bit    m_valid;
    bit    m_ready;
    beat_t b;
    m_valid = (q.size() > 0);
    m_ready = (q.size() < 2) && !reset;
    b.alu = alu_result_i; b.sd = store_data_i; b.we = we_i;
    b.sm = select_mem_i; b.ds = data_input_s_i; b.don = data_input_on_i;
    if (reset) begin
      q.delete();
      m_cnt = 0;
    end else begin
      if (m_valid && !ready_i && m_cnt < CNT_MAX) m_cnt++;
      if (flush) begin
        q.delete();
      end else begin
        if (m_valid && ready_i) void'(q.pop_front());
        if (valid_i && m_ready) q.push_back(b);
      end
    end
  endtask

  task automatic compare_all();
    beat_t h;
    logic [DATA_W-1:0] f;
    h = '{default: '0};
    f = '0;
    if (q.size() > 0) begin
      h = q[0];
      f = q[q.size()-1].alu;
    end
    chk("ready_o",   64'(ready_o),   64'((q.size() < 2) && !reset));
    chk("valid_o",   64'(valid_o),   64'(q.size() > 0));
    chk("alu_o",     64'(alu_result_o), 64'(h.alu));
    chk("store_o",   64'(store_data_o), 64'(h.sd));
    chk("we_o",      64'(we_o),      64'(h.we));
    chk("sel_mem_o", 64'(select_mem_o), 64'(h.sm));
    chk("din_s_o",   64'(data_input_s_o), 64'(h.ds));
    chk("din_on_o",  64'(data_input_on_o), 64'(h.don));
    chk("fwd_valid", 64'(fwd_valid_o), 64'(q.size() > 0));
    chk("fwd_data",  64'(fwd_data_o), 64'(f));
    chk("occupancy", 64'(occupancy_o), 64'(q.size()));
    chk("stall_cnt", 64'(stall_cnt_o), 64'(m_cnt));
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] a, input logic w, input logic r);
    valid_i = v; alu_result_i = a; store_data_i = a + 32'h100; we_i = w; ready_i = r;
    select_mem_i = a[0]; data_input_s_i = a[1]; data_input_on_i = a[2];
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    repeat (3) tick();
    chk("rst_ready", 64'(ready_o), 64'd0);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_alu",   64'(alu_result_o), 64'd0);
    chk("rst_stall", 64'(stall_cnt_o), 64'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", 64'(ready_o), 64'd1);
    chk("post_rst_occ",   64'(occupancy_o), 64'd0);

    // streaming
    drive(1'b1, 32'h10, 1'b1, 1'b1); tick();
    chk("str0_alu", 64'(alu_result_o), 64'h10); chk("str0_we", 64'(we_o), 64'd1);
    drive(1'b1, 32'h20, 1'b1, 1'b1); tick();
    chk("str1_alu", 64'(alu_result_o), 64'h20); chk("str1_occ", 64'(occupancy_o), 64'd1);
    drive(1'b1, 32'h30, 1'b1, 1'b1); tick();
    chk("str2_alu", 64'(alu_result_o), 64'h30); chk("str2_valid", 64'(valid_o), 64'd1);
    drive(1'b0, '0, 1'b0, 1'b1); tick();
    chk("str_drain_occ", 64'(occupancy_o), 64'd0);

    // backpressure
    drive(1'b1, 32'hA, 1'b1, 1'b0); tick();
    drive(1'b1, 32'hB, 1'b0, 1'b0); tick();
    chk("bp_occ",   64'(occupancy_o), 64'd2);
    chk("bp_ready", 64'(ready_o), 64'd0);
    chk("bp_fwd",   64'(fwd_data_o), 64'hB);
    chk("bp_stall1", 64'(stall_cnt_o), 64'd1);
    drive(1'b0, '0, 1'b0, 1'b0); tick();
    chk("bp_stall2", 64'(stall_cnt_o), 64'd2);
    chk("bp_head",  64'(alu_result_o), 64'hA);
    drive(1'b0, '0, 1'b0, 1'b1); tick();
    chk("bp_head2", 64'(alu_result_o), 64'hB);
    chk("bp_ready2", 64'(ready_o), 64'd1);
    tick();
    chk("bp_empty", 64'(valid_o), 64'd0);

    // flush while full, with a beat arriving in the flush cycle
    drive(1'b1, 32'h1, 1'b1, 1'b0); tick();
    drive(1'b1, 32'h2, 1'b1, 1'b0); tick();
    chk("fl_pre_occ", 64'(occupancy_o), 64'd2);
    flush = 1'b1; drive(1'b1, 32'hC, 1'b1, 1'b0); tick();
    chk("fl_valid", 64'(valid_o), 64'd0);
    chk("fl_we",    64'(we_o), 64'd0);
    chk("fl_occ",   64'(occupancy_o), 64'd0);
    chk("fl_stall", 64'(stall_cnt_o), 64'd4);
    flush = 1'b0; drive(1'b0, '0, 1'b0, 1'b0); tick();
    chk("fl_noC",   64'(alu_result_o), 64'd0);

    // stall counter saturation
    drive(1'b1, 32'h5, 1'b0, 1'b0); tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    repeat (20) tick();
    chk("sat_stall", 64'(stall_cnt_o), 64'd15);

    // reset while full
    drive(1'b1, 32'h6, 1'b1, 1'b0); tick();
    chk("rf_occ", 64'(occupancy_o), 64'd2);
    reset = 1'b1; drive(1'b0, '0, 1'b0, 1'b0); tick();
    chk("rf_valid", 64'(valid_o), 64'd0);
    chk("rf_stall", 64'(stall_cnt_o), 64'd0);
    chk("rf_fwd",   64'(fwd_data_o), 64'd0);
    reset = 1'b0;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      valid_i         = ($urandom_range(0, 3) != 0);
      ready_i         = ($urandom_range(0, 9) < ((i / 500) % 2 == 0 ? 7 : 3));
      alu_result_i    = $urandom;
      store_data_i    = $urandom;
      we_i            = $urandom_range(0, 1);
      select_mem_i    = $urandom_range(0, 1);
      data_input_s_i  = $urandom_range(0, 1);
      data_input_on_i = $urandom_range(0, 1);
      flush           = ($urandom_range(0, 39) == 0);
      reset           = ($urandom_range(0, 199) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
